serdes_test_sequencer: RTL and testbench

Run controller for the OSERDES/ISERDES loopback test datapath (LFSR generator → serializer → comparator). Holds the datapath in reset, releases it, masks the comparator's start-up error period, and then counts comparator errors over a fixed window. It repeats this for a programmed number of runs and reports a pass/fail summary. It sits next to the test datapath in the top-level hardware test and replaces free-running, testbench-driven reset.

---
 rtl/serdes_test_pkg.sv | 31 +++
 rtl/serdes_test_sequencer_if.sv | 30 +++
 rtl/serdes_test_sequencer_phase_timer.sv | 30 +++
 rtl/serdes_test_sequencer.sv | 164 ++++++++++++++++
 tb/tb_serdes_test_sequencer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/serdes_test_pkg.sv
// Shared types, default phase lengths and width helpers for the SERDES
// loopback test sequencer.
package serdes_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_t;

  localparam int DEF_RESET_CYCLES  = 16;
  localparam int DEF_SETTLE_CYCLES = 64;
  localparam int DEF_WINDOW_CYCLES = 1024;
  localparam int DEF_NUM_RUNS      = 4;
  localparam int DEF_ERR_WIDTH     = 16;

  // clog2 with a floor of one bit, so single-value ranges still get a real vector
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serdes_test_sequencer_if.sv
// Control/status bundle between the test sequencer and its environment.
// slave is the sequencer side, master drives START/ABORT and the error flag.
interface serdes_test_sequencer_if
  import serdes_test_pkg::*;
#(
  parameter int RUN_W  = width_of(DEF_NUM_RUNS),
  parameter int FAIL_W = width_of(DEF_NUM_RUNS + 1),
  parameter int ERR_W  = DEF_ERR_WIDTH
);
  logic              START;
  logic              ABORT;
  logic              DP_ERROR;
  logic              DP_RST;
  logic              BUSY;
  logic              DONE;
  logic              PASS;
  logic [RUN_W-1:0]  RUN_IDX;
  logic [ERR_W-1:0]  ERR_CNT;
  logic [FAIL_W-1:0] FAIL_RUNS;

  modport master (
    output START, ABORT, DP_ERROR,
    input  DP_RST, BUSY, DONE, PASS, RUN_IDX, ERR_CNT, FAIL_RUNS
  );

  modport slave (
    input  START, ABORT, DP_ERROR,
    output DP_RST, BUSY, DONE, PASS, RUN_IDX, ERR_CNT, FAIL_RUNS
  );
endinterface

// File: rtl/serdes_test_sequencer_phase_timer.sv
// Loadable down-counter shared by the RESET, SETTLE and CHECK phases.
// Load with (length - 1) on phase entry; zero marks the last phase cycle.
module phase_timer
  import serdes_test_pkg::*;
#(
  parameter int WIDTH = width_of(DEF_WINDOW_CYCLES)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);
  logic [WIDTH-1:0] count_r;

  // Count down to zero and park there until the next load
  always_ff @(posedge CLK) begin
    if (!RST) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != '0) begin
      count_r <= count_r - WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);
endmodule

// File: rtl/serdes_test_sequencer.sv
// Run controller for the OSERDES/ISERDES loopback datapath: reset, settle
// (errors masked), then count comparator errors over a window, NUM_RUNS times.
module serdes_test_sequencer
  import serdes_test_pkg::*;
#(
  parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int NUM_RUNS      = DEF_NUM_RUNS,
  parameter int ERR_WIDTH     = DEF_ERR_WIDTH
) (
  input logic CLK,
  input logic RST,
  serdes_test_sequencer_if.slave bus
);
  localparam int RUN_W   = width_of(NUM_RUNS);
  localparam int FAIL_W  = width_of(NUM_RUNS + 1);
  localparam int TIMER_W = width_of(max3(RESET_CYCLES, SETTLE_CYCLES, WINDOW_CYCLES));

  localparam logic [RUN_W-1:0]   LAST_RUN    = RUN_W'(NUM_RUNS - 1);
  localparam logic [TIMER_W-1:0] RESET_LOAD  = TIMER_W'(RESET_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WINDOW_LOAD = TIMER_W'(WINDOW_CYCLES - 1);

  seq_state_t         state_r, state_n;
  logic [RUN_W-1:0]   run_idx_r, run_idx_n;
  logic [ERR_WIDTH-1:0] err_cnt_r, err_cnt_n;
  logic [FAIL_W-1:0]  fail_runs_r, fail_runs_n;
  logic               run_err_r, run_err_n;
  logic               pass_r, pass_n;
  logic               dp_rst_r, busy_r, done_r;
  logic               timer_load_s;
  logic [TIMER_W-1:0] timer_val_s;
  logic               timer_zero_s;

  phase_timer #(.WIDTH(TIMER_W)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (timer_load_s),
    .load_val (timer_val_s),
    .zero     (timer_zero_s)
  );

  // Next-state, counter updates and timer loads; ABORT overrides everything
  always_comb begin
    state_n      = state_r;
    run_idx_n    = run_idx_r;
    err_cnt_n    = err_cnt_r;
    fail_runs_n  = fail_runs_r;
    run_err_n    = run_err_r;
    pass_n       = pass_r;
    timer_load_s = 1'b0;
    timer_val_s  = '0;
    if (bus.ABORT) begin
      state_n = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (bus.START) begin
            state_n      = ST_RESET;
            run_idx_n    = '0;
            err_cnt_n    = '0;
            fail_runs_n  = '0;
            run_err_n    = 1'b0;
            pass_n       = 1'b0;
            timer_load_s = 1'b1;
            timer_val_s  = RESET_LOAD;
          end else begin
            state_n = state_r;
          end
        end
        ST_RESET: begin
          if (timer_zero_s) begin
            state_n      = ST_SETTLE;
            timer_load_s = 1'b1;
            timer_val_s  = SETTLE_LOAD;
          end else begin
            state_n = ST_RESET;
          end
        end
        ST_SETTLE: begin
          if (timer_zero_s) begin
            state_n      = ST_CHECK;
            timer_load_s = 1'b1;
            timer_val_s  = WINDOW_LOAD;
          end else begin
            state_n = ST_SETTLE;
          end
        end
        ST_CHECK: begin
          if (bus.DP_ERROR) begin
            run_err_n = 1'b1;
            if (err_cnt_r != '1) begin
              err_cnt_n = err_cnt_r + ERR_WIDTH'(1);
            end else begin
              err_cnt_n = err_cnt_r;
            end
          end else begin
            run_err_n = run_err_r;
          end
          if (timer_zero_s) begin
            state_n = ST_NEXT;
          end else begin
            state_n = ST_CHECK;
          end
        end
        ST_NEXT: begin
          if (run_err_r) begin
            fail_runs_n = fail_runs_r + FAIL_W'(1);
          end else begin
            fail_runs_n = fail_runs_r;
          end
          run_err_n = 1'b0;
          if (run_idx_r == LAST_RUN) begin
            state_n = ST_DONE;
            pass_n  = (fail_runs_n == '0);
          end else begin
            state_n      = ST_RESET;
            run_idx_n    = run_idx_r + RUN_W'(1);
            timer_load_s = 1'b1;
            timer_val_s  = RESET_LOAD;
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and status outputs, all registered from the next state
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r     <= ST_IDLE;
      run_idx_r   <= '0;
      err_cnt_r   <= '0;
      fail_runs_r <= '0;
      run_err_r   <= 1'b0;
      pass_r      <= 1'b0;
      dp_rst_r    <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      run_idx_r   <= run_idx_n;
      err_cnt_r   <= err_cnt_n;
      fail_runs_r <= fail_runs_n;
      run_err_r   <= run_err_n;
      pass_r      <= pass_n;
      dp_rst_r    <= (state_n == ST_IDLE) || (state_n == ST_RESET) || (state_n == ST_DONE);
      busy_r      <= (state_n == ST_RESET) || (state_n == ST_SETTLE) ||
                     (state_n == ST_CHECK) || (state_n == ST_NEXT);
      done_r      <= (state_n == ST_DONE);
    end
  end

  assign bus.DP_RST    = dp_rst_r;
  assign bus.BUSY      = busy_r;
  assign bus.DONE      = done_r;
  assign bus.PASS      = pass_r;
  assign bus.RUN_IDX   = run_idx_r;
  assign bus.ERR_CNT   = err_cnt_r;
  assign bus.FAIL_RUNS = fail_runs_r;
endmodule

// File: tb/tb_serdes_test_sequencer.sv
// Scoreboard bench for serdes_test_sequencer: each test pushes its expected
// trace summary; a negedge monitor checks per-cycle status and final results.
module tb_serdes_test_sequencer;
  import serdes_test_pkg::*;

  localparam int RC = 4, SC = 8, WC = 32, NR = 3, EW = 4;
  localparam int RUN_LEN = RC + SC + WC + 1;   // 45
  localparam int CHK     = 1 + RC + SC;        // first CHECK offset of run 0
  localparam int TOTAL   = 1 + NR * RUN_LEN;   // offset where DONE appears
  localparam int ERR_MAX = (1 << EW) - 1;
  localparam int RUN_W   = width_of(NR);
  localparam int FAIL_W  = width_of(NR + 1);

  typedef struct {
    int start;
    int abort_off;   // 0 = runs to completion
    int kind;        // 0 none, 1 ABORT, 2 ABORT+START, 3 RST
    int err;
    int fail;
    int run;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  serdes_test_sequencer_if #(.RUN_W(RUN_W), .FAIL_W(FAIL_W), .ERR_W(EW)) bus ();

  serdes_test_sequencer #(
    .RESET_CYCLES(RC), .SETTLE_CYCLES(SC), .WINDOW_CYCLES(WC),
    .NUM_RUNS(NR), .ERR_WIDTH(EW)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares the DUT against the head-of-queue expectation
  always @(negedge CLK) begin
    exp_t rec;
    int   o;
    if (sb_q.size() > 0) begin
      rec = sb_q[0];
      o = cyc - rec.start;
      if (o >= 1) begin
        if (rec.abort_off > 0 && o == rec.abort_off + 1) begin
          chk("abort_dp_rst", int'(bus.DP_RST), 1);
          chk("abort_busy", int'(bus.BUSY), 0);
          chk("abort_done", int'(bus.DONE), 0);
          chk("abort_pass", int'(bus.PASS), 0);
          chk("abort_err_cnt", int'(bus.ERR_CNT), rec.err);
          chk("abort_fail_runs", int'(bus.FAIL_RUNS), rec.fail);
          chk("abort_run_idx", int'(bus.RUN_IDX), rec.run);
          void'(sb_q.pop_front());
        end else if (rec.abort_off == 0 && o == TOTAL) begin
          chk("final_done", int'(bus.DONE), 1);
          chk("final_busy", int'(bus.BUSY), 0);
          chk("final_dp_rst", int'(bus.DP_RST), 1);
          chk("final_pass", int'(bus.PASS), (rec.fail == 0) ? 1 : 0);
          chk("final_err_cnt", int'(bus.ERR_CNT), rec.err);
          chk("final_fail_runs", int'(bus.FAIL_RUNS), rec.fail);
          chk("final_run_idx", int'(bus.RUN_IDX), rec.run);
          void'(sb_q.pop_front());
        end else if (o < TOTAL) begin
          chk("run_busy", int'(bus.BUSY), 1);
          chk("run_done", int'(bus.DONE), 0);
          chk("run_dp_rst", int'(bus.DP_RST), (((o - 1) % RUN_LEN) < RC) ? 1 : 0);
          chk("run_run_idx", int'(bus.RUN_IDX), (o - 1) / RUN_LEN);
          if (o == 1) begin
            chk("start_err_cnt", int'(bus.ERR_CNT), 0);
            chk("start_fail_runs", int'(bus.FAIL_RUNS), 0);
          end
        end
      end
    end
  end

  // One test: build DP_ERROR pattern, predict the outcome, drive it
  task automatic do_test(input int mode, input int abort_off, input int kind,
                         input int extra_start);
    bit   pat [0:TOTAL];
    int   cnt;
    int   limit, sum, fail, last, p;
    exp_t rec;
    for (int o = 0; o <= TOTAL; o++) begin
      p = (o >= 1) ? (o - 1) % RUN_LEN : 0;
      case (mode)
        1: pat[o] = (o >= 1 && o < TOTAL) && ((p >= RC && p < RC + SC) || p == RUN_LEN - 1);
        2: pat[o] = (o >= CHK + RUN_LEN + 3) && (o <= CHK + RUN_LEN + 7);
        3: pat[o] = (o >= CHK) && (o <= CHK + WC - 1);
        4: pat[o] = (o == CHK) || (o == CHK + 2 * RUN_LEN + WC - 1);
        5: pat[o] = ($urandom_range(0, 19) == 0);
        default: pat[o] = 1'b0;
      endcase
    end
    limit = (abort_off > 0) ? abort_off : TOTAL + 1;
    sum = 0;
    fail = 0;
    for (int r = 0; r < NR; r++) begin
      cnt = 0;
      for (int k = 0; k < WC; k++)
        if (pat[CHK + r * RUN_LEN + k] && (CHK + r * RUN_LEN + k) < limit) cnt++;
      sum += cnt;
      if (cnt > 0 && RUN_LEN * (r + 1) < limit) fail++;
    end
    rec.abort_off = abort_off;
    rec.kind = kind;
    rec.err  = (sum > ERR_MAX) ? ERR_MAX : sum;
    rec.fail = fail;
    rec.run  = (abort_off > 0) ? (abort_off - 1) / RUN_LEN : NR - 1;
    if (kind == 3) begin
      rec.err = 0;
      rec.fail = 0;
      rec.run = 0;
    end
    bus.START = 1'b1;
    bus.ABORT = 1'b0;
    bus.DP_ERROR = pat[0];
    rec.start = cyc;
    sb_q.push_back(rec);
    last = (abort_off > 0) ? abort_off : TOTAL;
    for (int o = 1; o <= last; o++) begin
      @(posedge CLK); #1;
      bus.START    = (o == extra_start) || (kind == 2 && o == abort_off);
      bus.ABORT    = (kind == 1 || kind == 2) && (o == abort_off);
      RST          = !(kind == 3 && o == abort_off);
      bus.DP_ERROR = pat[o];
    end
    @(posedge CLK); #1;
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    bus.DP_ERROR = 1'b0;
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("sb_drain", sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b0;
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    bus.DP_ERROR = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_dp_rst", int'(bus.DP_RST), 1);
    chk("rst_busy", int'(bus.BUSY), 0);
    chk("rst_done", int'(bus.DONE), 0);
    chk("rst_pass", int'(bus.PASS), 0);
    chk("rst_run_idx", int'(bus.RUN_IDX), 0);
    chk("rst_err_cnt", int'(bus.ERR_CNT), 0);
    chk("rst_fail_runs", int'(bus.FAIL_RUNS), 0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;

    do_test(0, 0, 0, 0);          // clean pass
    do_test(1, 0, 0, 0);          // errors only while masked
    do_test(2, 0, 0, 0);          // five errors in run 1
    do_test(3, 0, 0, 0);          // saturation in run 0
    do_test(4, 0, 0, 0);          // window edges
    do_test(0, 0, 0, 60);         // START mid-run ignored; restart from DONE
    for (int i = 0; i < 4; i++) do_test(5, 0, 0, $urandom_range(2, 130));
    do_test(2, 65, 1, 0);         // ABORT in run 1 CHECK
    do_test(5, 30, 2, 0);         // ABORT+START together
    do_test(5, 7, 3, 0);          // RST during SETTLE
    for (int i = 0; i < 4; i++) do_test(5, $urandom_range(1, TOTAL - 1), $urandom_range(1, 3), 0);
    do_test(0, 0, 0, 0);          // recovers to a clean pass

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
